// File: rtl/select_encode_sequencer.sv
// Control-step sequencer: fetch plus per-opcode T-steps for load/store/ALU.
// Define ILLEGAL_TRAP_EN to halt with illegal=1 on unlisted opcodes.
module select_encode_sequencer #(
   parameter int BITS        = 32,
   parameter int OPCODE_BITS = 5
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   run,
   input  logic [BITS-1:0]        IR,
   input  logic                   mem_ready,
   output logic                   PCout,
   output logic                   MARin,
   output logic                   IncPC,
   output logic                   PCin,
   output logic                   Read,
   output logic                   Write,
   output logic                   MDRin,
   output logic                   MDRout,
   output logic                   IRin,
   output logic                   Yin,
   output logic                   Zin,
   output logic                   Zlowout,
   output logic                   Cout,
   output logic                   Gra,
   output logic                   Grb,
   output logic                   Grc,
   output logic                   Rin,
   output logic                   Rout,
   output logic                   BAout,
   output logic [OPCODE_BITS-1:0] alu_op,
   output logic                   halted,
   output logic                   illegal
);

   localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(5'b00000);
   localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(5'b00001);
   localparam logic [OPCODE_BITS-1:0] OP_ST   = OPCODE_BITS'(5'b00010);
   localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(5'b00011);
   localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(5'b00100);
   localparam logic [OPCODE_BITS-1:0] OP_AND  = OPCODE_BITS'(5'b00101);
   localparam logic [OPCODE_BITS-1:0] OP_OR   = OPCODE_BITS'(5'b00110);
   localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5'b01100);
   localparam logic [OPCODE_BITS-1:0] OP_ANDI = OPCODE_BITS'(5'b01101);
   localparam logic [OPCODE_BITS-1:0] OP_ORI  = OPCODE_BITS'(5'b01110);
   localparam logic [OPCODE_BITS-1:0] OP_NOP  = OPCODE_BITS'(5'b11010);
   localparam logic [OPCODE_BITS-1:0] OP_HALT = OPCODE_BITS'(5'b11011);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3,
      S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [OPCODE_BITS-1:0] op_q;
   logic [OPCODE_BITS-1:0] i_alu_op;
   logic                   is_r, is_i, is_ldi, is_ld, is_st;
   logic                   is_nop, is_halt, is_ill;
   logic                   is_alu, is_addr, is_mem;
   logic                   unused_ir;

   assign unused_ir = ^IR[BITS-OPCODE_BITS-1:0];

   // Opcode is latched once, at the T2->T3 decision
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
         op_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_T2)
            op_q <= IR[BITS-1 -: OPCODE_BITS];
      end
   end

   always_comb begin
      is_r    = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                (op_q == OP_AND) || (op_q == OP_OR);
      is_i    = (op_q == OP_ADDI) || (op_q == OP_ANDI) ||
                (op_q == OP_ORI);
      is_ldi  = (op_q == OP_LDI);
      is_ld   = (op_q == OP_LD);
      is_st   = (op_q == OP_ST);
      is_nop  = (op_q == OP_NOP);
      is_halt = (op_q == OP_HALT);
      is_alu  = is_r || is_i;
      is_addr = is_ldi || is_ld || is_st;
      is_mem  = is_ld || is_st;
      is_ill  = !(is_alu || is_addr || is_nop || is_halt);
      if (op_q == OP_ADDI)
         i_alu_op = OP_ADD;
      else if (op_q == OP_ANDI)
         i_alu_op = OP_AND;
      else
         i_alu_op = OP_OR;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (run) state_nxt = S_T0;
         S_T0:   state_nxt = S_T1;
         S_T1:   if (mem_ready) state_nxt = S_T2;
         S_T2:   state_nxt = S_T3;
         S_T3: begin
            unique case (1'b1)
               is_halt: state_nxt = S_HALT;
               is_nop:  state_nxt = S_T0;
`ifdef ILLEGAL_TRAP_EN
               is_ill:  state_nxt = S_HALT;
`else
               is_ill:  state_nxt = S_T0;
`endif
               default: state_nxt = S_T4;
            endcase
         end
         S_T4:   state_nxt = S_T5;
         S_T5:   state_nxt = is_mem ? S_T6 : S_T0;
         // st's T6 is a register-to-MDR move; only ld waits there
         S_T6:   if (is_st || mem_ready) state_nxt = S_T7;
         S_T7:   if (is_ld || mem_ready) state_nxt = S_T0;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      PCout   = 1'b0;
      MARin   = 1'b0;
      IncPC   = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      Cout    = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      BAout   = 1'b0;
      alu_op  = '0;
      halted  = (state == S_HALT);
`ifdef ILLEGAL_TRAP_EN
      illegal = (state == S_HALT) && is_ill;
`else
      illegal = 1'b0;
`endif
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Grb   = is_alu || is_addr;
            Yin   = is_alu || is_addr;
            Rout  = is_alu;
            BAout = is_addr;
         end
         S_T4: begin
            Zin  = is_alu || is_addr;
            Grc  = is_r;
            Rout = is_r;
            Cout = is_i || is_addr;
            if (is_r)
               alu_op = op_q;
            else if (is_i)
               alu_op = i_alu_op;
            else if (is_addr)
               alu_op = OP_ADD;
         end
         S_T5: begin
            Zlowout = is_alu || is_addr;
            MARin   = is_mem;
            Gra     = (is_alu || is_ldi);
            Rin     = (is_alu || is_ldi);
         end
         S_T6: begin
            Read  = is_ld;
            MDRin = is_mem;
            Gra   = is_st;
            Rout  = is_st;
         end
         S_T7: begin
            MDRout = is_ld;
            Gra    = is_ld;
            Rin    = is_ld;
            Write  = is_st;
         end
         default: ;
      endcase
   end

endmodule
